// File: rtl/order_tx_serializer.sv
// Egress framer: header 0xA5, payload MSB-first, XOR checksum; stamps egress time and latency.
// Optional latency statistics are compiled in with `TX_LAT_STATS_EN.
module order_tx_serializer #(
  parameter int unsigned MSG_BYTES = 8,
  parameter int unsigned TS_W      = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dec_valid,
  output logic                   dec_ready,
  input  logic [8*MSG_BYTES-1:0] dec_payload,
  input  logic [TS_W-1:0]        dec_ingress_ts,
  output logic [7:0]             tx_byte,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   tx_last,
  output logic [TS_W-1:0]        ts_now,
  output logic [TS_W-1:0]        egress_ts,
  output logic [TS_W-1:0]        latency,
  output logic                   lat_valid,
  input  logic                   stats_clr,
  output logic [TS_W-1:0]        lat_max,
  output logic [TS_W-1:0]        lat_min,
  output logic [31:0]            frame_cnt
);

  localparam int unsigned PAY_W    = 8 * MSG_BYTES;
  localparam int unsigned IDX_W    = $clog2(MSG_BYTES + 1);
  localparam logic [7:0]  HDR_BYTE = 8'hA5;

  typedef enum logic [1:0] {IDLE, HDR, PAY, CSUM} state_t;

  state_t            state_q, state_d;
  logic [PAY_W-1:0]  payload_q, payload_d;
  logic [TS_W-1:0]   ingress_q, ingress_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [7:0]        csum_q, csum_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              tx_valid_q, tx_valid_d;
  logic              tx_last_q, tx_last_d;
  logic [TS_W-1:0]   ts_now_q, ts_now_d;
  logic [TS_W-1:0]   egress_q, egress_d;
  logic [TS_W-1:0]   latency_q, latency_d;
  logic              lat_valid_q, lat_valid_d;
  logic              tx_hs;
  logic              frame_done;

  assign tx_hs      = tx_valid_q && tx_ready;
  assign frame_done = (state_q == CSUM) && tx_hs;

  // Next-byte values are computed one cycle ahead so tx_* come straight from flops.
  always_comb begin
    state_d     = state_q;
    payload_d   = payload_q;
    ingress_d   = ingress_q;
    idx_d       = idx_q;
    csum_d      = csum_q;
    tx_byte_d   = tx_byte_q;
    tx_valid_d  = tx_valid_q;
    tx_last_d   = tx_last_q;
    egress_d    = egress_q;
    latency_d   = latency_q;
    lat_valid_d = 1'b0;
    ts_now_d    = ts_now_q + TS_W'(1);
    case (state_q)
      IDLE: begin
        if (dec_valid) begin
          payload_d  = dec_payload;
          ingress_d  = dec_ingress_ts;
          csum_d     = 8'h00;
          idx_d      = '0;
          tx_byte_d  = HDR_BYTE;
          tx_valid_d = 1'b1;
          tx_last_d  = 1'b0;
          state_d    = HDR;
        end
      end
      HDR: begin
        if (tx_hs) begin
          idx_d       = '0;
          tx_byte_d   = payload_q[PAY_W-1 -: 8];
          payload_d   = payload_q << 8;
          egress_d    = ts_now_q;
          latency_d   = ts_now_q - ingress_q;
          lat_valid_d = 1'b1;
          state_d     = PAY;
        end
      end
      PAY: begin
        if (tx_hs) begin
          csum_d = csum_q ^ tx_byte_q;
          idx_d  = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(MSG_BYTES - 1)) begin
            tx_byte_d = csum_q ^ tx_byte_q;
            tx_last_d = 1'b1;
            state_d   = CSUM;
          end else begin
            tx_byte_d = payload_q[PAY_W-1 -: 8];
            payload_d = payload_q << 8;
          end
        end
      end
      CSUM: begin
        if (tx_hs) begin
          tx_byte_d  = 8'h00;
          tx_valid_d = 1'b0;
          tx_last_d  = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      payload_q   <= '0;
      ingress_q   <= '0;
      idx_q       <= '0;
      csum_q      <= 8'h00;
      tx_byte_q   <= 8'h00;
      tx_valid_q  <= 1'b0;
      tx_last_q   <= 1'b0;
      ts_now_q    <= '0;
      egress_q    <= '0;
      latency_q   <= '0;
      lat_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      payload_q   <= payload_d;
      ingress_q   <= ingress_d;
      idx_q       <= idx_d;
      csum_q      <= csum_d;
      tx_byte_q   <= tx_byte_d;
      tx_valid_q  <= tx_valid_d;
      tx_last_q   <= tx_last_d;
      ts_now_q    <= ts_now_d;
      egress_q    <= egress_d;
      latency_q   <= latency_d;
      lat_valid_q <= lat_valid_d;
    end
  end

  assign dec_ready = (state_q == IDLE);
  assign tx_byte   = tx_byte_q;
  assign tx_valid  = tx_valid_q;
  assign tx_last   = tx_last_q;
  assign ts_now    = ts_now_q;
  assign egress_ts = egress_q;
  assign latency   = latency_q;
  assign lat_valid = lat_valid_q;

`ifdef TX_LAT_STATS_EN
  logic [TS_W-1:0] lat_max_q, lat_max_d;
  logic [TS_W-1:0] lat_min_q, lat_min_d;
  logic [31:0]     frame_cnt_q, frame_cnt_d;

  // Clear takes priority over a same-cycle update.
  always_comb begin
    lat_max_d   = lat_max_q;
    lat_min_d   = lat_min_q;
    frame_cnt_d = frame_cnt_q;
    if (stats_clr) begin
      lat_max_d   = '0;
      lat_min_d   = '1;
      frame_cnt_d = '0;
    end else begin
      if (lat_valid_q) begin
        if (latency_q > lat_max_q) lat_max_d = latency_q;
        if (latency_q < lat_min_q) lat_min_d = latency_q;
      end
      if (frame_done && (frame_cnt_q != 32'hFFFF_FFFF)) frame_cnt_d = frame_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_max_q   <= '0;
      lat_min_q   <= '1;
      frame_cnt_q <= '0;
    end else begin
      lat_max_q   <= lat_max_d;
      lat_min_q   <= lat_min_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign lat_max   = lat_max_q;
  assign lat_min   = lat_min_q;
  assign frame_cnt = frame_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = stats_clr ^ frame_done;
  assign lat_max      = '0;
  assign lat_min      = '0;
  assign frame_cnt    = '0;
`endif

endmodule

// File: tb/tb_order_tx_serializer.sv
// Directed bench for order_tx_serializer: framing, backpressure, latency wrap, stats, mid-frame reset.
module tb_order_tx_serializer;

  localparam int unsigned MSG_BYTES = 8;
  localparam int unsigned TS_W      = 32;
`ifdef TX_LAT_STATS_EN
  localparam bit          STATS   = 1'b1;
  localparam logic [31:0] MIN_RST = 32'hFFFF_FFFF;
`else
  localparam bit          STATS   = 1'b0;
  localparam logic [31:0] MIN_RST = 32'h0;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   dec_valid;
  logic                   dec_ready;
  logic [8*MSG_BYTES-1:0] dec_payload;
  logic [TS_W-1:0]        dec_ingress_ts;
  logic [7:0]             tx_byte;
  logic                   tx_valid;
  logic                   tx_ready;
  logic                   tx_last;
  logic [TS_W-1:0]        ts_now;
  logic [TS_W-1:0]        egress_ts;
  logic [TS_W-1:0]        latency;
  logic                   lat_valid;
  logic                   stats_clr;
  logic [TS_W-1:0]        lat_max;
  logic [TS_W-1:0]        lat_min;
  logic [31:0]            frame_cnt;

  logic [TS_W-1:0] tb_ts;
  int checks = 0;
  int failures = 0;

  order_tx_serializer #(.MSG_BYTES(MSG_BYTES), .TS_W(TS_W)) dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_payload(dec_payload), .dec_ingress_ts(dec_ingress_ts),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last),
    .ts_now(ts_now), .egress_ts(egress_ts), .latency(latency), .lat_valid(lat_valid),
    .stats_clr(stats_clr), .lat_max(lat_max), .lat_min(lat_min), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Reference timestamp counter.
  always @(posedge clk or posedge rst) begin
    if (rst) tb_ts <= '0;
    else     tb_ts <= tb_ts + 32'd1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic apply_reset();
    rst = 1'b1; dec_valid = 1'b0; tx_ready = 1'b1; stats_clr = 1'b0;
    dec_payload = '0; dec_ingress_ts = '0;
    repeat (3) @(negedge clk);
  endtask

  // Sends one message timed for the requested latency and checks every byte of the frame.
  task automatic run_frame(input logic [63:0] pay, input logic [31:0] want_lat,
                           input int stall_idx, input int stall_len, input string name,
                           output logic [31:0] eg, output logic [31:0] lt);
    logic [7:0]  exp_b[10];
    logic [7:0]  csum;
    logic [31:0] ingress;
    logic [31:0] exp_eg;
    int k, stalls, guard, pulses;
    csum = 8'h00;
    exp_b[0] = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      exp_b[i+1] = pay[63-8*i -: 8];
      csum = csum ^ pay[63-8*i -: 8];
    end
    exp_b[9] = csum;
    guard = 0;
    while (dec_ready !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
    checks++;
    if (dec_ready !== 1'b1) begin
      failures++; $display("FAIL %s_ready: dec_ready=%b, required 1", name, dec_ready);
    end
    exp_eg  = tb_ts + 32'd1;
    ingress = exp_eg - want_lat;
    dec_payload = pay; dec_ingress_ts = ingress; dec_valid = 1'b1; tx_ready = 1'b1;
    @(negedge clk);
    dec_valid = 1'b0; dec_payload = '0; dec_ingress_ts = '1;
    k = 0; stalls = 0; guard = 0; pulses = 0; eg = '0; lt = '0;
    while (k < 10 && guard < 100) begin
      if (lat_valid === 1'b1) begin pulses++; eg = egress_ts; lt = latency; end
      if (k == stall_idx && stalls < stall_len) begin tx_ready = 1'b0; stalls++; end
      else tx_ready = 1'b1;
      checks++;
      if (tx_valid !== 1'b1 || tx_byte !== exp_b[k] || tx_last !== 1'(k == 9)) begin
        failures++;
        $display("FAIL %s_byte%0d: valid=%b byte=%h last=%b, required valid=1 byte=%h last=%b",
                 name, k, tx_valid, tx_byte, tx_last, exp_b[k], k == 9);
      end
      if (tx_ready) k++;
      guard++;
      @(negedge clk);
    end
    tx_ready = 1'b1;
    checks++;
    if (k != 10) begin failures++; $display("FAIL %s_done: bytes=%0d, required 10", name, k); end
    checks++;
    if (pulses != 1) begin failures++; $display("FAIL %s_latpulse: pulses=%0d, required 1", name, pulses); end
    checks++;
    if (lt !== want_lat) begin failures++; $display("FAIL %s_latency: got %h, required %h", name, lt, want_lat); end
    checks++;
    if (eg !== exp_eg) begin failures++; $display("FAIL %s_egress: got %h, required %h", name, eg, exp_eg); end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL rst_tx_valid: got %b, required 0", tx_valid); end
    checks++; if (dec_ready !== 1'b1) begin failures++; $display("FAIL rst_dec_ready: got %b, required 1", dec_ready); end
    checks++; if (tx_last !== 1'b0) begin failures++; $display("FAIL rst_tx_last: got %b, required 0", tx_last); end
    checks++; if (tx_byte !== 8'h00) begin failures++; $display("FAIL rst_tx_byte: got %h, required 00", tx_byte); end
    checks++; if (ts_now !== 32'h0) begin failures++; $display("FAIL rst_ts_now: got %h, required 0", ts_now); end
    checks++; if (egress_ts !== 32'h0 || latency !== 32'h0 || lat_valid !== 1'b0) begin
      failures++; $display("FAIL rst_lat: egress=%h latency=%h lat_valid=%b, required 0 0 0", egress_ts, latency, lat_valid);
    end
    checks++; if (lat_max !== 32'h0 || lat_min !== MIN_RST || frame_cnt !== 32'h0) begin
      failures++; $display("FAIL rst_stats: max=%h min=%h cnt=%0d, required 0 %h 0", lat_max, lat_min, frame_cnt, MIN_RST);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (ts_now !== 32'd4) begin failures++; $display("FAIL ts_count: got %0d, required 4", ts_now); end
  endtask

  task automatic test_single_frame();
    logic [31:0] eg, lt;
    run_frame(64'h0102030405060708, 32'd20, -1, 0, "single", eg, lt);
    checks++; if (dec_ready !== 1'b1 || tx_valid !== 1'b0) begin
      failures++; $display("FAIL single_idle: dec_ready=%b tx_valid=%b, required 1 0", dec_ready, tx_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] eg, lt;
    run_frame(64'h0102030405060708, 32'd7, 3, 4, "bp", eg, lt);
    run_frame(64'hDEADBEEF00FF1234, 32'd3, 9, 2, "bp_csum", eg, lt);
  endtask

  task automatic test_latency_wrap();
    logic [31:0] eg, lt;
    apply_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (ts_now !== tb_ts) begin failures++; $display("FAIL wrap_ts: got %h, required %h", ts_now, tb_ts); end
    run_frame(64'h1122334455667788, 32'd5, -1, 0, "wrap", eg, lt);
    checks++; if (eg !== 32'd3 || lt !== 32'd5) begin
      failures++; $display("FAIL wrap_values: egress=%h latency=%h, required 3 5", eg, lt);
    end
  endtask

  task automatic test_stats();
    logic [31:0] eg, lt;
    apply_reset();
    rst = 1'b0;
    @(negedge clk);
    run_frame(64'h0000000000000001, 32'd10, -1, 0, "st1", eg, lt);
    run_frame(64'h0000000000000002, 32'd4, -1, 0, "st2", eg, lt);
    run_frame(64'h0000000000000003, 32'd7, -1, 0, "st3", eg, lt);
    checks++; if (lat_max !== (STATS ? 32'd10 : 32'd0)) begin failures++; $display("FAIL stats_max: got %0d", lat_max); end
    checks++; if (lat_min !== (STATS ? 32'd4 : 32'd0)) begin failures++; $display("FAIL stats_min: got %0d", lat_min); end
    checks++; if (frame_cnt !== (STATS ? 32'd3 : 32'd0)) begin failures++; $display("FAIL stats_cnt: got %0d", frame_cnt); end
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    checks++; if (lat_max !== 32'h0 || lat_min !== MIN_RST || frame_cnt !== 32'h0) begin
      failures++; $display("FAIL stats_clr: max=%h min=%h cnt=%0d, required 0 %h 0", lat_max, lat_min, frame_cnt, MIN_RST);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] eg, lt;
    int pulses;
    pulses = 0;
    dec_payload = 64'h0102030405060708; dec_ingress_ts = tb_ts; dec_valid = 1'b1; tx_ready = 1'b1;
    @(negedge clk);
    dec_valid = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (tx_byte !== 8'h05 || tx_valid !== 1'b1) begin
      failures++; $display("FAIL mid_pos: byte=%h valid=%b, required 05 1", tx_byte, tx_valid);
    end
    rst = 1'b1;
    #1;
    checks++; if (tx_valid !== 1'b0 || tx_last !== 1'b0) begin
      failures++; $display("FAIL mid_abort: valid=%b last=%b, required 0 0", tx_valid, tx_last);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (lat_valid === 1'b1 || tx_valid === 1'b1) pulses++;
      @(negedge clk);
    end
    checks++; if (pulses != 0 || frame_cnt !== 32'h0) begin
      failures++; $display("FAIL mid_quiet: activity=%0d cnt=%0d, required 0 0", pulses, frame_cnt);
    end
    run_frame(64'hA1B2C3D4E5F60718, 32'd6, -1, 0, "after_rst", eg, lt);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_latency_wrap();
    test_stats();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/order_tx_serializer.md
# order_tx_serializer

Egress transmitter for the low-latency path. It accepts one decision message per handshake, serializes it into a framed byte stream (header, payload MSB-first, XOR checksum) over a valid/ready byte interface, and stamps the egress timestamp when the first byte leaves. It also reports per-frame latency against the ingress timestamp carried with the message. It sits after the decision logic, at the opposite end of the byte pipeline from the ingress register stages, and provides the shared timestamp counter.

## Interface
- `MSG_BYTES`, default 8: payload bytes per message, legal range 1..16.
- `TS_W`, default 32: timestamp and latency width.
- `clk`, in, 1: single clock.
- `rst`, in, 1: reset, asynchronous and active-high.
- `dec_valid`, in, 1: decision message valid.
- `dec_ready`, out, 1: block can accept a message.
- `dec_payload`, in, 8*MSG_BYTES: message bytes; byte 0 is the MSB.
- `dec_ingress_ts`, in, TS_W: ingress timestamp of the message.
- `tx_byte`, out, 8: outgoing byte.
- `tx_valid`, out, 1: `tx_byte` is valid.
- `tx_ready`, in, 1: downstream accepts the byte.
- `tx_last`, out, 1: current byte is the checksum, i.e. the final byte of the frame.
- `ts_now`, out, TS_W: free-running timestamp counter.
- `egress_ts`, out, TS_W: `ts_now` value at the header handshake.
- `latency`, out, TS_W: `egress_ts - dec_ingress_ts`, modulo 2^TS_W.
- `lat_valid`, out, 1: one-cycle pulse when `latency` and `egress_ts` update.
- `stats_clr`, in, 1: clears latency statistics.
- `lat_max`, out, TS_W: maximum latency since the last clear.
- `lat_min`, out, TS_W: minimum latency since the last clear.
- `frame_cnt`, out, 32: frames completed since the last clear.

## Operation
- FSM states: IDLE, HDR, PAY, CSUM.
  - IDLE: `dec_ready`=1. When `dec_valid` is seen, latch payload and ingress_ts, clear the checksum, go to HDR.
  - HDR: `tx_byte`=0xA5. On handshake, go to PAY with byte index 0.
  - PAY: `tx_byte`=payload byte[index]. On handshake, XOR the byte into the checksum and increment the index. After byte MSG_BYTES-1, go to CSUM.
  - CSUM: `tx_byte`=XOR of all payload bytes, `tx_last`=1. On handshake, go to IDLE.
- `dec_ready` is high only in IDLE, so there is a one-cycle bubble between frames. A frame is MSG_BYTES+2 bytes.
- `tx_valid`=1 in HDR, PAY and CSUM.
- Handshake is `tx_valid && tx_ready`. While `tx_ready`=0, `tx_byte`, `tx_last` and the state hold stable.
- The upstream side may drop `dec_valid` at any time; the block only samples it in IDLE.
- `ts_now` increments every cycle and wraps from all-ones to 0.
- Header handshake: capture `egress_ts` ← `ts_now` and `latency` ← `ts_now - ingress_latch`, truncated to TS_W (wrap-safe).
- `rst` asserted mid-frame aborts the frame immediately, with no partial checksum and no `lat_valid`.

## Timing
- Outputs are registered, with no combinational paths from inputs to `tx_*`. The single exception is `dec_ready`, which depends only on state.
- Message accepted at cycle N → header appears with `tx_valid` at N+1.
- Header handshake at cycle H → `egress_ts`, `latency` and `lat_valid`=1 are all visible at H+1. `lat_valid` lasts one cycle.
- With `tx_ready` held at 1, frames occupy MSG_BYTES+2 cycles, and a new message is accepted every MSG_BYTES+3 cycles.
- Values on `rst`:
  - State IDLE; `dec_ready`=1; `tx_valid`=0; `tx_last`=0.
  - `tx_byte`, `ts_now`, `egress_ts`, `latency` = 0; `lat_valid`=0.
  - `lat_max`=0; `lat_min`=all-ones; `frame_cnt`=0.

## Configuration
- Macro: `TX_LAT_STATS_EN`.
- Defined:
  - On each `lat_valid`, `lat_max` and `lat_min` update with `latency`.
  - `frame_cnt` increments on each CSUM handshake and saturates at all-ones.
  - `stats_clr` restores the reset values of the three statistics.
  - If `stats_clr` coincides with an update, the clear wins.
- Undefined: the statistics logic is removed. The ports remain; `lat_max`=0, `lat_min`=0, `frame_cnt`=0 constantly, and `stats_clr` is ignored.

## Test plan
- Reset: assert `rst` for 3 cycles → `tx_valid`=0, `dec_ready`=1, `ts_now`=0, `lat_min`=0xFFFFFFFF (stats build), all other outputs 0.
- Single frame: MSG_BYTES=8, payload 0x0102030405060708, `tx_ready`=1 → bytes A5 01 02 03 04 05 06 07 08 08 on consecutive cycles, `tx_last` only on the last byte, `dec_ready` back to 1 the next cycle.
- Backpressure: drop `tx_ready` for 4 cycles during payload byte 0x03 → 0x03 held stable with `tx_valid`=1, and the frame content is unchanged.
- Latency wrap: ingress_ts=0xFFFFFFFE, header handshake when `ts_now`=0x00000003 → `latency`=5, `egress_ts`=3, and `lat_valid` is high for exactly one cycle.
- Stats (stats build): three frames with latencies 10, 4, 7 → `lat_max`=10, `lat_min`=4, `frame_cnt`=3. Then pulse `stats_clr` → 0, 0xFFFFFFFF, 0.
- Reset mid-frame: assert `rst` during payload byte 4 → `tx_valid`=0 immediately, with no `lat_valid` and no checksum byte. The next accepted message frames correctly from the header.
